// File: rtl/calc_pkg.sv
// calc_pkg: shared constants, state/key encodings and keypad lookup for the
// calculator keypad controller.
package calc_pkg;

  localparam int unsigned GRID_COLS  = 3;
  localparam int unsigned GRID_ROWS  = 4;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned VAL_W      = 17;
  localparam int unsigned POS_W      = 4;
  localparam int unsigned DIG_W      = 3;
  localparam int unsigned KEY_N      = 5;

  // Largest operand representable with the given number of decimal digits
  function automatic int unsigned calc_max_val(input int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

  localparam int unsigned MAX_VAL = calc_max_val(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2
  } calc_state_e;

  typedef enum logic [3:0] {
    KEY_D0  = 4'd0,
    KEY_D1  = 4'd1,
    KEY_D2  = 4'd2,
    KEY_D3  = 4'd3,
    KEY_D4  = 4'd4,
    KEY_D5  = 4'd5,
    KEY_D6  = 4'd6,
    KEY_D7  = 4'd7,
    KEY_D8  = 4'd8,
    KEY_D9  = 4'd9,
    KEY_ADD = 4'd10,
    KEY_EQ  = 4'd11
  } key_code_e;

  // One-hot navigation/OK action produced by the edge detector
  typedef struct packed {
    logic ok;
    logic up;
    logic down;
    logic left;
    logic right;
  } key_act_t;

  // Button face at (row, col) of the keypad grid
  function automatic key_code_e calc_key_at(input logic [POS_W-1:0] row,
                                            input logic [POS_W-1:0] col);
    key_code_e code;
    case (row)
      4'd0:    code = (col == 4'd0) ? KEY_D1  : (col == 4'd1) ? KEY_D2 : KEY_D3;
      4'd1:    code = (col == 4'd0) ? KEY_D4  : (col == 4'd1) ? KEY_D5 : KEY_D6;
      4'd2:    code = (col == 4'd0) ? KEY_D7  : (col == 4'd1) ? KEY_D8 : KEY_D9;
      default: code = (col == 4'd0) ? KEY_ADD : (col == 4'd1) ? KEY_D0 : KEY_EQ;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/calc_key_edge.sv
// calc_key_edge: rising-edge detection on the five debounced keys with a
// fixed-priority encode (ok > up > down > left > right) to a one-hot action.
module calc_key_edge
  import calc_pkg::*;
(
  input  logic             clk_in,
  input  logic             sys_rst_n,
  input  logic [KEY_N-1:0] keys_i,   // {ok, up, down, left, right}
  output key_act_t         act_c
);

  logic [KEY_N-1:0] prev_q;
  logic [KEY_N-1:0] rise_c;

  // Previous key levels for edge detection
  always_ff @(posedge clk_in) begin
    if (!sys_rst_n) prev_q <= '0;
    else            prev_q <= keys_i;
  end

  assign rise_c = keys_i & ~prev_q;

  // Keep only the highest-priority new press this cycle
  always_comb begin
    act_c = '0;
    if      (rise_c[4]) act_c.ok    = 1'b1;
    else if (rise_c[3]) act_c.up    = 1'b1;
    else if (rise_c[2]) act_c.down  = 1'b1;
    else if (rise_c[1]) act_c.left  = 1'b1;
    else if (rise_c[0]) act_c.right = 1'b1;
  end

endmodule

// File: rtl/calc_keypad_ctrl.sv
// calc_keypad_ctrl: keypad cursor navigation and decimal adder sequencing for
// the calculator LCD UI. Optional macro CALC_CURSOR_WRAP_EN makes the cursor
// wrap around grid edges instead of saturating.
module calc_keypad_ctrl
  import calc_pkg::*;
(
  input  logic             clk_in,
  input  logic             sys_rst_n,
  input  logic             key_up,
  input  logic             key_down,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             key_ok,
  output logic [POS_W-1:0] cursor_x,
  output logic [POS_W-1:0] cursor_y,
  output logic [VAL_W-1:0] disp_value,
  output logic [DIG_W-1:0] disp_digits,
  output logic [1:0]       calc_state,
  output logic             err_ovf
);

  key_act_t         act_c;
  logic [POS_W-1:0] x_q, y_q;
  calc_state_e      state_q;
  logic [VAL_W-1:0] opa_q, opb_q, res_q, disp_q;
  logic [DIG_W-1:0] dig_q;
  logic             err_q;

  calc_key_edge u_key_edge (
    .clk_in    (clk_in),
    .sys_rst_n (sys_rst_n),
    .keys_i    ({key_ok, key_up, key_down, key_left, key_right}),
    .act_c     (act_c)
  );

  key_code_e        key_c;
  logic             is_digit_c;
  logic [VAL_W-1:0] digit_c, cur_op_c, ent_op_c, sum_c, sat_c;
  logic [DIG_W-1:0] ent_dig_c;
  logic             can_enter_c, ovf_c;
  logic [POS_W-1:0] y_up_c, y_dn_c, x_lt_c, x_rt_c;

  // Key under the cursor and operand-entry / adder helpers
  assign key_c       = calc_key_at(y_q, x_q);
  assign is_digit_c  = (key_c <= KEY_D9);
  assign digit_c     = VAL_W'(key_c);
  assign cur_op_c    = (state_q == S_B) ? opb_q : opa_q;
  assign ent_op_c    = cur_op_c * VAL_W'(10) + digit_c;
  assign ent_dig_c   = (cur_op_c == '0 && digit_c == '0) ? dig_q : dig_q + DIG_W'(1);
  assign can_enter_c = (dig_q < DIG_W'(MAX_DIGITS));
  assign sum_c       = opa_q + opb_q;
  assign ovf_c       = (sum_c > VAL_W'(MAX_VAL));
  assign sat_c       = ovf_c ? VAL_W'(MAX_VAL) : sum_c;

  // Next cursor coordinate for each move direction at the grid edges
`ifdef CALC_CURSOR_WRAP_EN
  assign y_up_c = (y_q == '0) ? POS_W'(GRID_ROWS - 1) : y_q - POS_W'(1);
  assign y_dn_c = (y_q == POS_W'(GRID_ROWS - 1)) ? '0 : y_q + POS_W'(1);
  assign x_lt_c = (x_q == '0) ? POS_W'(GRID_COLS - 1) : x_q - POS_W'(1);
  assign x_rt_c = (x_q == POS_W'(GRID_COLS - 1)) ? '0 : x_q + POS_W'(1);
`else
  assign y_up_c = (y_q == '0) ? y_q : y_q - POS_W'(1);
  assign y_dn_c = (y_q == POS_W'(GRID_ROWS - 1)) ? y_q : y_q + POS_W'(1);
  assign x_lt_c = (x_q == '0) ? x_q : x_q - POS_W'(1);
  assign x_rt_c = (x_q == POS_W'(GRID_COLS - 1)) ? x_q : x_q + POS_W'(1);
`endif

  // Calculator FSM, operands, cursor and registered display value
  always_ff @(posedge clk_in) begin
    if (!sys_rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      state_q <= S_A;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      disp_q  <= '0;
      dig_q   <= '0;
      err_q   <= 1'b0;
    end else if (act_c.ok) begin
      if (is_digit_c) begin
        if (state_q == S_RES) begin
          // A digit after a result starts a fresh calculation
          opa_q   <= digit_c;
          disp_q  <= digit_c;
          dig_q   <= (digit_c == '0) ? '0 : DIG_W'(1);
          state_q <= S_A;
          err_q   <= 1'b0;
        end else if (can_enter_c) begin
          dig_q  <= ent_dig_c;
          disp_q <= ent_op_c;
          if (state_q == S_B) opb_q <= ent_op_c;
          else                opa_q <= ent_op_c;
        end
      end else if (key_c == KEY_ADD) begin
        opb_q   <= '0;
        dig_q   <= '0;
        disp_q  <= '0;
        state_q <= S_B;
        case (state_q)
          S_B: begin
            opa_q <= sat_c;
            if (ovf_c) err_q <= 1'b1;
          end
          S_RES:   opa_q <= res_q;
          default: ;
        endcase
      end else begin
        case (state_q)
          S_A: begin
            res_q   <= opa_q;
            disp_q  <= opa_q;
            dig_q   <= '0;
            state_q <= S_RES;
          end
          S_B: begin
            res_q   <= sat_c;
            disp_q  <= sat_c;
            dig_q   <= '0;
            state_q <= S_RES;
            if (ovf_c) err_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end else if (act_c.up) begin
      y_q <= y_up_c;
    end else if (act_c.down) begin
      y_q <= y_dn_c;
    end else if (act_c.left) begin
      x_q <= x_lt_c;
    end else if (act_c.right) begin
      x_q <= x_rt_c;
    end
  end

  assign cursor_x    = x_q;
  assign cursor_y    = y_q;
  assign disp_value  = disp_q;
  assign disp_digits = dig_q;
  assign calc_state  = state_q;
  assign err_ovf     = err_q;

endmodule

// File: tb/tb_calc_keypad_ctrl.sv
// tb_calc_keypad_ctrl: scoreboard bench for calc_keypad_ctrl. A behavioural
// model predicts outputs when keys are driven; predictions are queued and
// compared one cycle later. Honours CALC_CURSOR_WRAP_EN.
module tb_calc_keypad_ctrl;

`ifdef CALC_CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [4:0] K_OK = 5'b10000;
  localparam logic [4:0] K_UP = 5'b01000;
  localparam logic [4:0] K_DN = 5'b00100;
  localparam logic [4:0] K_LT = 5'b00010;
  localparam logic [4:0] K_RT = 5'b00001;

  logic        clk_in = 1'b0;
  logic        sys_rst_n;
  logic        key_up, key_down, key_left, key_right, key_ok;
  logic [3:0]  cursor_x, cursor_y;
  logic [16:0] disp_value;
  logic [2:0]  disp_digits;
  logic [1:0]  calc_state;
  logic        err_ovf;

  always #5 clk_in = ~clk_in;

  calc_keypad_ctrl dut (
    .clk_in      (clk_in),
    .sys_rst_n   (sys_rst_n),
    .key_up      (key_up),
    .key_down    (key_down),
    .key_left    (key_left),
    .key_right   (key_right),
    .key_ok      (key_ok),
    .cursor_x    (cursor_x),
    .cursor_y    (cursor_y),
    .disp_value  (disp_value),
    .disp_digits (disp_digits),
    .calc_state  (calc_state),
    .err_ovf     (err_ovf)
  );

  typedef struct packed {
    logic [3:0]  x;
    logic [3:0]  y;
    logic [16:0] val;
    logic [2:0]  dig;
    logic [1:0]  st;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  int mx, my, mst, ma, mb, mres, mdig, merr;
  // Button faces row-major; 10 = '+', 11 = '='
  int keymap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mst = 0; ma = 0; mb = 0; mres = 0; mdig = 0; merr = 0;
  endtask

  task automatic model_ok();
    int code, op, s;
    code = keymap[my * 3 + mx];
    if (code <= 9) begin
      if (mst == 2) begin
        ma = code; mdig = (code == 0) ? 0 : 1; mst = 0; merr = 0;
      end else if (mdig < 4) begin
        op = (mst == 0) ? ma : mb;
        if (!(op == 0 && code == 0)) mdig++;
        op = op * 10 + code;
        if (mst == 0) ma = op; else mb = op;
      end
    end else if (code == 10) begin
      if (mst == 1) begin
        s = ma + mb;
        if (s > 9999) begin s = 9999; merr = 1; end
        ma = s;
      end else if (mst == 2) begin
        ma = mres;
      end
      mb = 0; mdig = 0; mst = 1;
    end else begin
      if (mst == 0) begin
        mres = ma; mst = 2; mdig = 0;
      end else if (mst == 1) begin
        s = ma + mb;
        if (s > 9999) begin s = 9999; merr = 1; end
        mres = s; mst = 2; mdig = 0;
      end
    end
  endtask

  task automatic model_act(input logic [4:0] m);
    if (m[4]) model_ok();
    else if (m[3]) begin if (my > 0) my--; else if (WRAP) my = 3; end
    else if (m[2]) begin if (my < 3) my++; else if (WRAP) my = 0; end
    else if (m[1]) begin if (mx > 0) mx--; else if (WRAP) mx = 2; end
    else if (m[0]) begin if (mx < 2) mx++; else if (WRAP) mx = 0; end
  endtask

  task automatic sb_push();
    exp_t e;
    e.x   = 4'(mx);
    e.y   = 4'(my);
    e.val = 17'((mst == 0) ? ma : (mst == 1) ? mb : mres);
    e.dig = 3'(mdig);
    e.st  = 2'(mst);
    e.err = 1'(merr);
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    check_eq({tag, ".sb"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq({tag, ".x"},   32'(cursor_x),    32'(e.x));
      check_eq({tag, ".y"},   32'(cursor_y),    32'(e.y));
      check_eq({tag, ".val"}, 32'(disp_value),  32'(e.val));
      check_eq({tag, ".dig"}, 32'(disp_digits), 32'(e.dig));
      check_eq({tag, ".st"},  32'(calc_state),  32'(e.st));
      check_eq({tag, ".err"}, 32'(err_ovf),     32'(e.err));
    end
  endtask

  task automatic press(input logic [4:0] m, input string tag);
    {key_ok, key_up, key_down, key_left, key_right} = m;
    model_act(m);
    sb_push();
    tick();
    sb_compare(tag);
    {key_ok, key_up, key_down, key_left, key_right} = 5'b0;
    sb_push();
    tick();
    sb_compare({tag, ".rel"});
  endtask

  task automatic goto_cell(input int r, input int c);
    while (my > r) press(K_UP, "nav_up");
    while (my < r) press(K_DN, "nav_dn");
    while (mx > c) press(K_LT, "nav_lt");
    while (mx < c) press(K_RT, "nav_rt");
  endtask

  task automatic enter(input int code);
    int idx;
    idx = 0;
    for (int i = 0; i < 12; i++) if (keymap[i] == code) idx = i;
    goto_cell(idx / 3, idx % 3);
    press(K_OK, "ok");
  endtask

  task automatic hold_ok(input int n);
    key_ok = 1'b1;
    model_act(K_OK);
    sb_push();
    tick();
    sb_compare("hold0");
    for (int i = 1; i < n; i++) begin
      sb_push();
      tick();
      sb_compare("hold");
    end
    key_ok = 1'b0;
    sb_push();
    tick();
    sb_compare("hold.rel");
  endtask

  task automatic do_reset(input string tag);
    sys_rst_n = 1'b0;
    model_reset();
    sb_push();
    tick();
    sb_compare(tag);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    {key_ok, key_up, key_down, key_left, key_right} = 5'b0;
    sys_rst_n = 1'b0;
    tick();
    do_reset("reset");

    // Edges at (0,0): saturate or wrap
    press(K_LT, "edge_lt");
    press(K_UP, "edge_up");
    do_reset("reset2");

    // 1: right x3, down x5
    for (int i = 0; i < 3; i++) press(K_RT, "t1_rt");
    for (int i = 0; i < 5; i++) press(K_DN, "t1_dn");
    check_eq("t1_x", 32'(cursor_x), WRAP ? 32'd0 : 32'd2);
    check_eq("t1_y", 32'(cursor_y), WRAP ? 32'd1 : 32'd3);

    // 2: 12 + 34 =
    enter(1); enter(2);
    check_eq("t2_a", 32'(disp_value), 32'd12);
    enter(10);
    check_eq("t2_plus", 32'(disp_value), 32'd0);
    enter(3); enter(4);
    check_eq("t2_b", 32'(disp_value), 32'd34);
    enter(11);
    check_eq("t2_res", 32'(disp_value), 32'd46);
    check_eq("t2_st", 32'(calc_state), 32'd2);
    check_eq("t2_err", 32'(err_ovf), 32'd0);

    // 3: digit limit and overflow saturation
    for (int i = 0; i < 5; i++) enter(9);
    check_eq("t3_a", 32'(disp_value), 32'd9999);
    check_eq("t3_dig", 32'(disp_digits), 32'd4);
    enter(10);
    for (int i = 0; i < 4; i++) enter(9);
    enter(11);
    check_eq("t3_res", 32'(disp_value), 32'd9999);
    check_eq("t3_err", 32'(err_ovf), 32'd1);

    // 4: held OK acts once; OK beats UP
    goto_cell(1, 1);
    hold_ok(10);
    check_eq("t4_hold", 32'(disp_value), 32'd5);
    check_eq("t4_errclr", 32'(err_ovf), 32'd0);
    press(K_UP | K_OK, "t4_prio");
    check_eq("t4_prio_y", 32'(cursor_y), 32'd1);
    check_eq("t4_prio_v", 32'(disp_value), 32'd55);

    // 5: 5 + 5 + 5 = then 7
    do_reset("reset3");
    enter(5); enter(10); enter(5); enter(10);
    check_eq("t5_chain", 32'(disp_value), 32'd0);
    enter(5); enter(11);
    check_eq("t5_res", 32'(disp_value), 32'd15);
    enter(7);
    check_eq("t5_new", 32'(disp_value), 32'd7);
    check_eq("t5_st", 32'(calc_state), 32'd0);

    // Leading zero keeps digit count at 0
    do_reset("reset4");
    enter(0);
    check_eq("lz_dig", 32'(disp_digits), 32'd0);

    // 6: reset mid-entry
    enter(10); enter(1); enter(2); enter(3);
    check_eq("t6_pre", 32'(disp_value), 32'd123);
    do_reset("t6_rst");
    check_eq("t6_val", 32'(disp_value), 32'd0);
    check_eq("t6_x", 32'(cursor_x), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
